// File: rtl/trivium_word_adapter.sv
// Word-level front end for a bit-serial Trivium core: serialises key/IV loading,
// then encrypts 32-bit words one bit per cycle with valid/ready handshakes on both sides.
module trivium_word_adapter #(
  parameter int unsigned WAIT_MAX = 4095
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [79:0] key_i,
  input  logic [79:0] iv_i,
  input  logic        start_i,
  input  logic [31:0] in_dat_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] out_dat_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  input  logic        fin_i,
  output logic        busy_o,
  output logic        err_o,
  output logic        core_dat_o,
  output logic        core_get_dat_o,
  output logic        core_ld_keys_o,
  output logic        core_end_o,
  input  logic        core_dat_i,
  input  logic        core_ready_i
);

  localparam int unsigned WaitW = $clog2(WAIT_MAX + 1);
  localparam logic [WaitW-1:0] WaitMaxC = WaitW'(WAIT_MAX);

  typedef enum logic [3:0] {
    StIdle, StKey, StIv, StLoad, StWaitRdy, StWord, StPrime, StShift, StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [79:0]      key_q, key_d;
  logic [79:0]      iv_q, iv_d;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      sreg_q, sreg_d;
  // Holds serial bits 0..30; bit 31 is taken straight from the core on the last edge.
  logic [30:0]      cap_q, cap_d;
  logic [31:0]      out_dat_q, out_dat_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q     <= StIdle;
      key_q       <= '0;
      iv_q        <= '0;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      sreg_q      <= '0;
      cap_q       <= '0;
      out_dat_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      iv_q        <= iv_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      sreg_q      <= sreg_d;
      cap_q       <= cap_d;
      out_dat_q   <= out_dat_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    iv_d           = iv_q;
    bit_cnt_d      = bit_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    sreg_d         = sreg_q;
    cap_d          = cap_q;
    out_dat_d      = out_dat_q;
    out_valid_d    = out_valid_q;
    err_d          = err_q;
    in_ready_o     = 1'b0;
    core_dat_o     = 1'b0;
    core_get_dat_o = 1'b0;
    core_ld_keys_o = 1'b0;
    core_end_o     = 1'b0;

    // Consumption is independent of state; a word loaded in SHIFT below overrides it.
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          key_d     = key_i;
          iv_d      = iv_i;
          err_d     = 1'b0;
          bit_cnt_d = '0;
          state_d   = StKey;
        end
      end
      StKey: begin
        core_get_dat_o = 1'b1;
        core_dat_o     = key_q[bit_cnt_q];
        if (bit_cnt_q == 7'd79) begin
          bit_cnt_d = '0;
          state_d   = StIv;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end
      StIv: begin
        core_get_dat_o = 1'b1;
        core_dat_o     = iv_q[bit_cnt_q];
        if (bit_cnt_q == 7'd79) begin
          core_ld_keys_o = 1'b1;
          bit_cnt_d      = '0;
          state_d        = StLoad;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end
      StLoad: begin
        core_get_dat_o = 1'b1;
        wait_cnt_d     = '0;
        state_d        = StWaitRdy;
      end
      StWaitRdy: begin
        if (wait_cnt_q != WaitMaxC) wait_cnt_d = wait_cnt_q + 1'b1;
        if (core_ready_i) begin
          state_d = StWord;
        end else if (wait_cnt_q == WaitMaxC) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWord: begin
        in_ready_o = !out_valid_q || out_ready_i;
        if (in_valid_i && in_ready_o) begin
          sreg_d  = in_dat_i;
          state_d = StPrime;
        end else if (fin_i) begin
          state_d = StFinish;
        end
      end
      StPrime: begin
        core_get_dat_o = 1'b1;
        bit_cnt_d      = '0;
        state_d        = StShift;
      end
      StShift: begin
        core_get_dat_o = 1'b1;
        core_dat_o     = sreg_q[0];
        sreg_d         = {1'b0, sreg_q[31:1]};
        cap_d          = {core_dat_i, cap_q[30:1]};
        if (bit_cnt_q == 7'd31) begin
          out_dat_d   = {core_dat_i, cap_q};
          out_valid_d = 1'b1;
          state_d     = StWord;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end
      StFinish: begin
        core_end_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_dat_o   = out_dat_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

endmodule
